reg_bank_controller: RTL and testbench
======================================

# reg_bank_controller

Parametrised successor to the per-block register generator: decodes a level-held req/ack memory port onto a bank of `NUMBER_REGISTERS` registers at a configurable base address. Adds byte strobes, configurable read latency, decode-error responses and write-priority arbitration, which the previous generation lacks. Sits between the AXI-lite-to-mem bridge and the register slices of any config/status block.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; multiple of 8; `STRB_W = DATA_WIDTH/8`.
- `NUMBER_REGISTERS`, 10, register count, 1..256.
- `BASE_ADDR`, 0, byte address of register 0; aligned to `STRB_W`.
- `RD_LATENCY`, 1, cycles from read accept to `mem_r_ack`, 1..4.
- `DECERR_DATA`, 'hBAD_CAFE, read data returned on decode error.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `mem_w_req` in 1: write request, level, held until ack.
- `mem_w_addr` in ADDR_WIDTH: write byte address.
- `mem_w_data` in DATA_WIDTH: write data.
- `mem_w_strb` in STRB_W: byte enables.
- `mem_w_ack` out 1: one-cycle write completion.
- `mem_w_err` out 1: decode error, valid with `mem_w_ack`.
- `mem_r_req` in 1: read request, level, held until ack.
- `mem_r_addr` in ADDR_WIDTH: read byte address.
- `mem_r_data` out DATA_WIDTH: read data, valid with `mem_r_ack`, held until the next read completes.
- `mem_r_ack` out 1: one-cycle read completion.
- `mem_r_err` out 1: decode error, valid with `mem_r_ack`.
- `reg_wr_en` out NUMBER_REGISTERS: one-hot write pulse to the slices.
- `reg_wr_data` out DATA_WIDTH: registered write data.
- `reg_wr_strb` out STRB_W: registered byte enables.
- `reg_rd_en` out NUMBER_REGISTERS: one-hot read pulse, used for read-clear side effects.
- `reg_rd_data` in NUMBER_REGISTERS*DATA_WIDTH: flattened slice readback; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `err_count` out 16: saturating decode-error count.

## Operation
- Register i is at byte address `BASE_ADDR + i*STRB_W`.
- A decode hit requires: address ≥ BASE_ADDR, index < NUMBER_REGISTERS, and low log2(STRB_W) bits equal to zero. Any other address is a decode error.
- FSM states: IDLE, READ_WAIT, RESP.
- IDLE, `mem_w_req` high, `mem_w_ack` low:
  - Latch addr, data and strb; go to RESP.
  - Write has priority when both requests are high. The read stays pending and is accepted on the first IDLE cycle after the write ack.
- IDLE, only `mem_r_req` high, `mem_r_ack` low: latch addr. Go to READ_WAIT if RD_LATENCY>1, else RESP.
- READ_WAIT: count RD_LATENCY-1 cycles, then go to RESP.
- RESP: assert the ack, then return to IDLE.
  - Write hit with non-zero strobe: the one-hot `reg_wr_en` bit, `reg_wr_data` and `reg_wr_strb` are asserted in the same cycle as `mem_w_ack`.
  - Write with all-zero strobe: ack with err=0, no `reg_wr_en`.
  - Write decode error: ack with `mem_w_err`=1, no `reg_wr_en`.
  - Read hit: `mem_r_data` = `reg_rd_data` slice, sampled in the cycle before ack. The `reg_rd_en` bit pulses in the ack cycle, so the read-clear takes effect after the data is captured.
  - Read decode error: `mem_r_data` = DECERR_DATA, `mem_r_err`=1, no `reg_rd_en`.
- Every decode error increments `err_count`, which saturates at 16'hFFFF.
- Requester drops req before ack (protocol violation): the transaction still completes and acks.

## Timing
- Reset values: all outputs 0, including `mem_r_data` and `err_count`; FSM in IDLE.
- Write: req sampled in IDLE at cycle N → `mem_w_ack` and `reg_wr_en` at N+1.
- Read: req sampled at cycle N → `mem_r_ack` and `reg_rd_en` at N+RD_LATENCY.
- Ack is a single cycle. A req still high in the ack cycle is not re-accepted. The earliest next accept is the cycle after the ack.
- Back-to-back write then read (both high at N): `mem_w_ack` at N+1, read accepted at N+2, `mem_r_ack` at N+2+RD_LATENCY.
- `rst_n` low at any point clears state immediately. An in-flight transaction is dropped with no ack and no slice pulse.

## Configuration
- `REG_BANK_ERR_CNT_EN` defined: the `err_count` counter is implemented as described.
- Not defined: `err_count` is tied to 0 and no counter flops exist. Error flags are unaffected.

## Test plan
- Write hit, reset default parameters: addr 0x8, data 0xDEADBEEF, strb 0xF → `reg_wr_en`=0x004 and ack at N+1, err=0.
- Strobed write: addr 0x0, strb 0x3 → `reg_wr_strb`=0x3; a read of 0x0 returns the slice value with only bytes 0–1 changed.
- RD_LATENCY=3, read of 0x4 → ack exactly at N+3, `reg_rd_en`=0x002 in the ack cycle, data equals slice 1 value.
- Decode errors: write to 0x28 (10 regs), read from 0x2 (unaligned) → both err=1, read data 0xBADCAFE, no slice pulses, `err_count`=2 (0 without macro).
- Simultaneous write 0x0 and read 0x0 at N → write ack N+1, read ack N+2+RD_LATENCY, read returns the newly written data.
- `rst_n` pulsed low during READ_WAIT → no `mem_r_ack`, all outputs 0, next request serviced normally.

Source files
------------

// File: rtl/reg_bank_controller.sv
// reg_bank_controller
//   Decodes a level-held req/ack memory port onto a bank of NUMBER_REGISTERS
//   registers starting at BASE_ADDR. Writes take priority over reads, reads
//   complete RD_LATENCY cycles after acceptance, and unmapped or misaligned
//   addresses complete with an error flag instead of touching a slice.
//   Optional feature macro: REG_BANK_ERR_CNT_EN enables the saturating
//   decode-error counter on err_count; without it err_count is tied to 0.
module reg_bank_controller #(
   parameter int                    ADDR_WIDTH       = 32,
   parameter int                    DATA_WIDTH       = 32,
   parameter int                    NUMBER_REGISTERS = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0,
   parameter int                    RD_LATENCY       = 1,
   parameter logic [DATA_WIDTH-1:0] DECERR_DATA      = DATA_WIDTH'(32'h0BAD_CAFE)
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     mem_w_req,
   input  logic [ADDR_WIDTH-1:0]                    mem_w_addr,
   input  logic [DATA_WIDTH-1:0]                    mem_w_data,
   input  logic [DATA_WIDTH/8-1:0]                  mem_w_strb,
   output logic                                     mem_w_ack,
   output logic                                     mem_w_err,
   input  logic                                     mem_r_req,
   input  logic [ADDR_WIDTH-1:0]                    mem_r_addr,
   output logic [DATA_WIDTH-1:0]                    mem_r_data,
   output logic                                     mem_r_ack,
   output logic                                     mem_r_err,
   output logic [NUMBER_REGISTERS-1:0]              reg_wr_en,
   output logic [DATA_WIDTH-1:0]                    reg_wr_data,
   output logic [DATA_WIDTH/8-1:0]                  reg_wr_strb,
   output logic [NUMBER_REGISTERS-1:0]              reg_rd_en,
   input  logic [NUMBER_REGISTERS*DATA_WIDTH-1:0]   reg_rd_data,
   output logic [15:0]                              err_count
);

   localparam int                    STRB_W    = DATA_WIDTH / 8;
   localparam int                    SHIFT     = $clog2(STRB_W);
   localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ADDR_WIDTH'(STRB_W - 1);
   localparam logic [ADDR_WIDTH-1:0] NREG_A    = ADDR_WIDTH'(NUMBER_REGISTERS);
   // READ_WAIT lasts RD_LATENCY-1 cycles; the counter holds the cycles left after the current one
   localparam logic [1:0]            WAIT_INIT = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

   typedef enum logic [1:0] {IDLE, READ_WAIT, RESP} state_t;

   state_t                      state_reg;
   logic [1:0]                  wait_cnt_reg;
   logic [ADDR_WIDTH-1:0]       r_addr_reg;

   logic [ADDR_WIDTH:0]         w_diff;
   logic [ADDR_WIDTH:0]         r_diff;
   logic [ADDR_WIDTH-1:0]       w_off;
   logic [ADDR_WIDTH-1:0]       r_off;
   logic [ADDR_WIDTH-1:0]       r_addr_cur;
   logic                        w_hit;
   logic                        r_hit;
   logic [NUMBER_REGISTERS-1:0] w_sel;
   logic [NUMBER_REGISTERS-1:0] r_sel;
   logic [DATA_WIDTH-1:0]       r_slice;
   logic                        w_accept;
   logic                        r_accept;
   logic                        r_complete;

   // In IDLE the read decodes straight off the port so a one-cycle read needs no extra stage
   assign r_addr_cur = (state_reg == IDLE) ? mem_r_addr : r_addr_reg;

   // Borrow out of the subtraction flags addresses below the base without a constant compare
   assign w_diff = {1'b0, mem_w_addr} - {1'b0, BASE_ADDR};
   assign r_diff = {1'b0, r_addr_cur} - {1'b0, BASE_ADDR};
   assign w_off  = w_diff[ADDR_WIDTH-1:0];
   assign r_off  = r_diff[ADDR_WIDTH-1:0];

   assign w_hit = !w_diff[ADDR_WIDTH] && ((w_off >> SHIFT) < NREG_A) && ((w_off & LOW_MASK) == '0);
   assign r_hit = !r_diff[ADDR_WIDTH] && ((r_off >> SHIFT) < NREG_A) && ((r_off & LOW_MASK) == '0);

   // One-hot register selects, already qualified by a decode hit
   generate
      for (genvar gi = 0; gi < NUMBER_REGISTERS; gi++) begin : g_sel
         assign w_sel[gi] = w_hit && ((w_off >> SHIFT) == ADDR_WIDTH'(gi));
         assign r_sel[gi] = r_hit && ((r_off >> SHIFT) == ADDR_WIDTH'(gi));
      end
   endgenerate

   // AND-OR readback mux over the flattened slice bus
   always_comb begin
      r_slice = '0;
      for (int i = 0; i < NUMBER_REGISTERS; i++) begin
         if (r_sel[i]) begin
            r_slice = r_slice | reg_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Acceptance and read completion; writes win when both requests are present
   assign w_accept   = (state_reg == IDLE) && mem_w_req && !mem_w_ack;
   assign r_accept   = (state_reg == IDLE) && !mem_w_req && mem_r_req && !mem_r_ack;
   assign r_complete = (r_accept && (RD_LATENCY == 1)) ||
                       ((state_reg == READ_WAIT) && (wait_cnt_reg == 2'd0));

   // Transaction FSM; every port-facing output is registered here and RESP is the ack cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= 2'd0;
         r_addr_reg   <= '0;
         mem_w_ack    <= 1'b0;
         mem_w_err    <= 1'b0;
         mem_r_ack    <= 1'b0;
         mem_r_err    <= 1'b0;
         mem_r_data   <= '0;
         reg_wr_en    <= '0;
         reg_wr_data  <= '0;
         reg_wr_strb  <= '0;
         reg_rd_en    <= '0;
      end else begin
         mem_w_ack   <= 1'b0;
         mem_w_err   <= 1'b0;
         mem_r_ack   <= 1'b0;
         mem_r_err   <= 1'b0;
         reg_wr_en   <= '0;
         reg_wr_data <= '0;
         reg_wr_strb <= '0;
         reg_rd_en   <= '0;

         case (state_reg)
            IDLE: begin
               if (w_accept) begin
                  state_reg <= RESP;
                  mem_w_ack <= 1'b1;
                  mem_w_err <= !w_hit;
                  // An all-zero strobe completes cleanly but must not disturb any slice
                  if (w_hit && (|mem_w_strb)) begin
                     reg_wr_en   <= w_sel;
                     reg_wr_data <= mem_w_data;
                     reg_wr_strb <= mem_w_strb;
                  end
               end else if (r_accept) begin
                  r_addr_reg <= mem_r_addr;
                  if (RD_LATENCY > 1) begin
                     state_reg    <= READ_WAIT;
                     wait_cnt_reg <= WAIT_INIT;
                  end else begin
                     state_reg <= RESP;
                  end
               end
            end
            READ_WAIT: begin
               if (wait_cnt_reg == 2'd0) begin
                  state_reg <= RESP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 2'd1;
               end
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase

         // Data is captured on this edge while the read-clear pulse lands in the ack cycle
         if (r_complete) begin
            mem_r_ack  <= 1'b1;
            mem_r_err  <= !r_hit;
            mem_r_data <= r_hit ? r_slice : DECERR_DATA;
            reg_rd_en  <= r_sel;
         end
      end
   end

`ifdef REG_BANK_ERR_CNT_EN
   logic        err_event;
   logic [15:0] err_cnt_reg;

   assign err_event = (w_accept && !w_hit) || (r_complete && !r_hit);

   // Saturating decode-error counter, updated on the same edge that raises the error ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_reg <= 16'd0;
      end else if (err_event && (err_cnt_reg != 16'hFFFF)) begin
         err_cnt_reg <= err_cnt_reg + 16'd1;
      end
   end

   assign err_count = err_cnt_reg;
`else
   assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_reg_bank_controller.sv
// tb_reg_bank_controller
//   Table-driven and randomized checks of reg_bank_controller (RD_LATENCY=3)
//   against a transaction-level model of the register bank.
module tb_reg_bank_controller;

   localparam int          LAT    = 3;
   localparam int          NR     = 10;
   localparam logic [31:0] DECERR = 32'h0BAD_CAFE;
`ifdef REG_BANK_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              mem_w_req;
   logic [31:0]       mem_w_addr;
   logic [31:0]       mem_w_data;
   logic [3:0]        mem_w_strb;
   logic              mem_w_ack;
   logic              mem_w_err;
   logic              mem_r_req;
   logic [31:0]       mem_r_addr;
   logic [31:0]       mem_r_data;
   logic              mem_r_ack;
   logic              mem_r_err;
   logic [NR-1:0]     reg_wr_en;
   logic [31:0]       reg_wr_data;
   logic [3:0]        reg_wr_strb;
   logic [NR-1:0]     reg_rd_en;
   logic [NR*32-1:0]  reg_rd_data;
   logic [15:0]       err_count;

   int n_vec = 0;
   int n_mis = 0;

   reg_bank_controller #(.RD_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_w_req(mem_w_req), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
      .mem_w_strb(mem_w_strb), .mem_w_ack(mem_w_ack), .mem_w_err(mem_w_err),
      .mem_r_req(mem_r_req), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
      .mem_r_ack(mem_r_ack), .mem_r_err(mem_r_err),
      .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
      .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] slice_init(int i);
      return 32'hA5A5_0000 + 32'(i) * 32'h0000_1111;
   endfunction

   // Register slices: byte-strobed writes, register 9 is clear-on-read
   logic [31:0] slice_q [NR];
   always @(posedge clk) begin
      for (int i = 0; i < NR; i++) begin
         if (!rst_n) begin
            slice_q[i] <= slice_init(i);
         end else if (reg_wr_en[i]) begin
            for (int b = 0; b < 4; b++) begin
               if (reg_wr_strb[b]) slice_q[i][b*8 +: 8] <= reg_wr_data[b*8 +: 8];
            end
         end else if (reg_rd_en[i] && (i == 9)) begin
            slice_q[i] <= 32'd0;
         end
      end
   end

   always_comb begin
      reg_rd_data = '0;
      for (int i = 0; i < NR; i++) reg_rd_data[i*32 +: 32] = slice_q[i];
   end

   // Transaction-level reference model
   logic [31:0] model_regs [NR];
   int          model_errs;
   logic [31:0] last_rdata;

   task automatic model_reset();
      for (int i = 0; i < NR; i++) model_regs[i] = slice_init(i);
      model_errs = 0;
      last_rdata = 32'd0;
   endtask

   function automatic bit addr_hit(logic [31:0] a);
      return (a % 4 == 0) && (a / 4 < NR);
   endfunction

   function automatic logic [31:0] exp_cnt();
      return ERR_EN ? 32'(model_errs) : 32'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_flags"}, 32'({mem_w_ack, mem_w_err, mem_r_ack, mem_r_err}), 32'd0);
      chk({name, "_pulses"}, 32'({reg_wr_en, reg_rd_en}), 32'd0);
      chk({name, "_wdata"}, 32'(reg_wr_data) | 32'(reg_wr_strb), 32'd0);
      chk({name, "_rdata"}, mem_r_data, 32'd0);
      chk({name, "_errcnt"}, 32'(err_count), 32'd0);
   endtask

   // One request, waited on with a cycle budget; all expectations come from args and the model
   task automatic do_xact(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit exp_err, input logic [NR-1:0] exp_en);
      logic [31:0] exp_rd;
      bit          seen;
      int          lat;
      exp_rd = exp_err ? DECERR : model_regs[addr >> 2];
      seen   = 1'b0;
      lat    = 0;
      if (wr) begin
         mem_w_req = 1'b1; mem_w_addr = addr; mem_w_data = data; mem_w_strb = strb;
      end else begin
         mem_r_req = 1'b1; mem_r_addr = addr;
      end
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (wr ? mem_w_ack : mem_r_ack) begin
            seen = 1'b1;
            lat  = k;
            break;
         end
         chk("early_pulse", 32'({reg_wr_en, reg_rd_en}), 32'd0);
      end
      if (!seen) begin
         chk("ack_timeout", 32'd0, 32'd1);
      end else if (wr) begin
         chk("w_latency", 32'(lat), 32'd1);
         chk("w_err", 32'(mem_w_err), 32'(exp_err));
         chk("wr_en", 32'(reg_wr_en), 32'(exp_en));
         chk("w_rd_en", 32'({mem_r_ack, reg_rd_en}), 32'd0);
         if (exp_en != '0) begin
            chk("wr_data", reg_wr_data, data);
            chk("wr_strb", 32'(reg_wr_strb), 32'(strb));
         end
      end else begin
         chk("r_latency", 32'(lat), 32'(LAT));
         chk("r_err", 32'(mem_r_err), 32'(exp_err));
         chk("rd_en", 32'(reg_rd_en), 32'(exp_en));
         chk("r_data", mem_r_data, exp_rd);
         chk("r_wr_en", 32'({mem_w_ack, reg_wr_en}), 32'd0);
      end
      mem_w_req = 1'b0;
      mem_r_req = 1'b0;
      if (exp_err) model_errs++;
      if (wr && !exp_err) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) model_regs[addr >> 2][b*8 +: 8] = data[b*8 +: 8];
         end
      end
      if (!wr) begin
         last_rdata = exp_rd;
         if (!exp_err && (addr >> 2) == 9) model_regs[9] = 32'd0;
      end
      @(posedge clk); #1;
      chk("ack_single", 32'({mem_w_ack, mem_r_ack}), 32'd0);
      chk("r_data_hold", mem_r_data, last_rdata);
      chk("err_count", 32'(err_count), exp_cnt());
      $display("xact %s addr=0x%h data=0x%h strb=0x%h lat=%0d err=%0d", wr ? "WR" : "RD",
               addr, wr ? data : exp_rd, strb, lat, exp_err);
   endtask

   typedef struct {
      bit            wr;
      logic [31:0]   addr;
      logic [31:0]   data;
      logic [3:0]    strb;
      bit            exp_err;
      logic [NR-1:0] exp_en;
   } vec_t;

   vec_t tbl [12];

   initial begin
      tbl[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 1'b0, 10'h004};
      tbl[1]  = '{1'b1, 32'h0000_0000, 32'h1122_3344, 4'h3, 1'b0, 10'h001};
      tbl[2]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 10'h001};
      tbl[3]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 1'b0, 10'h002};
      tbl[4]  = '{1'b1, 32'h0000_0028, 32'h5555_AAAA, 4'hF, 1'b1, 10'h000};
      tbl[5]  = '{1'b0, 32'h0000_0002, 32'h0,         4'h0, 1'b1, 10'h000};
      tbl[6]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 10'h000};
      tbl[7]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 10'h010};
      tbl[8]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 1'b0, 10'h200};
      tbl[9]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 1'b0, 10'h200};
      tbl[10] = '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 1'b1, 10'h000};
      tbl[11] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 1'b0, 10'h004};
   end

   initial begin
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      bit          err;
      int          wk;
      int          rk;

      rst_n = 1'b0;
      mem_w_req = 1'b0; mem_w_addr = '0; mem_w_data = '0; mem_w_strb = '0;
      mem_r_req = 1'b0; mem_r_addr = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         do_xact(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].exp_err, tbl[i].exp_en);
      end

      // Simultaneous write and read of register 0: write first, read sees new data
      mem_w_req = 1'b1; mem_w_addr = 32'h0; mem_w_data = 32'hCAFE_F00D; mem_w_strb = 4'hF;
      mem_r_req = 1'b1; mem_r_addr = 32'h0;
      model_regs[0] = 32'hCAFE_F00D;
      wk = 0; rk = 0;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk); #1;
         if (mem_w_ack) begin
            wk = k;
            chk("sim_wr_en", 32'(reg_wr_en), 32'h001);
            mem_w_req = 1'b0;
         end
         if (mem_r_ack) begin
            rk = k;
            chk("sim_rd_en", 32'(reg_rd_en), 32'h001);
            chk("sim_rdata", mem_r_data, model_regs[0]);
            mem_r_req = 1'b0;
            break;
         end
      end
      mem_w_req = 1'b0; mem_r_req = 1'b0;
      last_rdata = model_regs[0];
      chk("sim_w_latency", 32'(wk), 32'd1);
      chk("sim_r_latency", 32'(rk), 32'(2 + LAT));
      $display("xact WR+RD addr=0x0 wk=%0d rk=%0d", wk, rk);
      @(posedge clk); #1;

      // Read request dropped right after acceptance still completes
      mem_r_req = 1'b1; mem_r_addr = 32'h8;
      @(posedge clk); #1;
      mem_r_req = 1'b0;
      rk = 0;
      for (int k = 2; k <= 12; k++) begin
         @(posedge clk); #1;
         if (mem_r_ack) begin
            rk = k;
            chk("drop_rdata", mem_r_data, model_regs[2]);
            break;
         end
      end
      last_rdata = model_regs[2];
      chk("drop_latency", 32'(rk), 32'(LAT));
      $display("xact RD(dropped req) addr=0x8 lat=%0d", rk);
      @(posedge clk); #1;

      // Randomized transactions against the model
      for (int n = 0; n < 40; n++) begin
         wr   = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 47));
         data = 32'($urandom);
         strb = 4'($urandom_range(0, 15));
         err  = !addr_hit(addr);
         do_xact(wr, addr, data, strb, err,
                 (!err && (!wr || strb != 4'h0)) ? (NR'(1) << (addr >> 2)) : '0);
      end

      // Reset asserted while a read sits in READ_WAIT
      mem_r_req = 1'b1; mem_r_addr = 32'h4;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      mem_r_req = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("mid_reset_no_ack", 32'({mem_r_ack, reg_rd_en}), 32'd0);
      end
      model_reset();
      rst_n = 1'b1;
      $display("xact RESET during READ_WAIT");
      @(posedge clk); #1;
      do_xact(1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 10'h002);
      do_xact(1'b1, 32'h2C, 32'h0, 4'hF, 1'b1, 10'h000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
